noc_port_sink_vc_buffer: RTL and testbench
==========================================

# noc_port_sink_vc_buffer

Receive-side endpoint of the NoC Stop&Go inter-tile link: it accepts the flits a switch output port drives on `network_valid`/`network_data`, stores them in per-virtual-channel FIFOs, and returns the per-VC `network_go` flow-control vector to the sender. Buffered flits are drained to a local consumer over a single valid/ready stream. A wormhole-aware round-robin arbiter keeps each packet contiguous on the output. The block terminates a switch port in tile and link testbenches, and is the building block for a switch input unit.

## Interface
- `NetworkFlitWidth`, 64: flit payload bits.
- `NetworkFlitTypeWidth`, 2: flit type field bits.
- `NetworkBroadcastWidth`, 1: broadcast field bits.
- `NetworkVirtualChannelIdWidth`, 1: VC id field bits; must be at least clog2(`NetworkNumberOfVirtualChannels`).
- `NetworkNumberOfVirtualChannels`, 2: number of VCs, 1..8.
- `BufferDepth`, 4: flits per VC FIFO; power of 2, at least 2.
- `TailFlitType`, 2'b10: type code of a tail flit.
- `HeaderTailFlitType`, 2'b11: type code of a single-flit packet.
- Derived: `NetworkDataWidth` = flit + type + broadcast + VC widths. Layout from MSB to LSB is {flit, type, broadcast, vc}.

Ports:
- `clk_network_i` in 1: the single clock.
- `rst_network_i` in 1: asynchronous, active-high reset.
- `network_valid_i` in 1: a flit is present on `network_data_i` this cycle.
- `network_data_i` in `NetworkDataWidth`: incoming flit.
- `network_go_o` out `NetworkNumberOfVirtualChannels`: per-VC permission to send.
- `m_valid_o` out 1: an output flit is available.
- `m_ready_i` in 1: the consumer accepts the output flit.
- `m_data_o` out `NetworkDataWidth`: output flit, VC id field preserved.
- `overflow_o` out 1: sticky protocol error flag.
- `stats_flits_o` out 32: count of accepted flits (see Configuration).

## Operation
- **Write side.** When `network_valid_i` is high, the VC id field selects the target FIFO.
  - If that FIFO is not full, the flit is written at the clock edge.
  - If it is full, or the VC id is at least `NetworkNumberOfVirtualChannels`, the flit is dropped and `overflow_o` is set. `overflow_o` is cleared only by reset.
- **Flow control.** `network_go_o[v]` is a register. At every edge it loads (`count_next[v]` < `BufferDepth`), where `count_next` includes this cycle's write and read.
  - The sender may drive a flit on VC v in cycle t only if it samples `network_go_o[v]` high in cycle t.
  - This is exact credit, with no slack slots.
- **Counters.** Each VC has a (clog2(`BufferDepth`)+1)-bit occupancy counter and wrapping read/write pointers.
  - A simultaneous write and read on the same VC leaves the count unchanged.
  - A write to a full FIFO is permitted only when a read on that same VC happens in the same cycle; this is not an overflow.
- **Arbiter.** Two states, `IDLE` and `LOCKED`, with a round-robin pointer `rr`.
  - In `IDLE`: select the first non-empty VC searching from `rr`+1 (modulo number of VCs). `m_valid_o` equals "some VC is non-empty". `m_data_o` is that VC's head flit.
  - On a transfer (`m_valid_o` && `m_ready_i`) in `IDLE`: `rr` takes the served VC.
    - If the flit type is not `TailFlitType` and not `HeaderTailFlitType`, go to `LOCKED` on that VC.
  - In `LOCKED`: `m_valid_o` equals "the locked VC is non-empty". Other VCs are not served.
    - A transfer of a `TailFlitType` or `HeaderTailFlitType` flit returns the arbiter to `IDLE`.
- `m_valid_o` and `m_data_o` are held stable while `m_valid_o` is high and `m_ready_i` is low, provided the arbiter stays in `LOCKED` or the selected VC is unchanged.
  - In `IDLE`, the selection may change only after a transfer.
  - Implement this with a registered selection that updates only when `m_valid_o` is low or a transfer completes.

## Timing
- Reset values:
  - `network_go_o` all ones.
  - `m_valid_o` 0; `m_data_o` 0.
  - `overflow_o` 0; `stats_flits_o` 0.
  - All counters and pointers 0; arbiter `IDLE`; `rr` = `NetworkNumberOfVirtualChannels`-1.
- Latency: a flit accepted at edge t appears on `m_data_o` no earlier than cycle t+1.
- `network_go_o[v]` falls in the cycle after the write that fills VC v. It rises in the cycle after the read that frees a slot.
- Reset asserted mid-packet discards all buffered flits and all arbiter state immediately.
- `m_data_o` is combinational from FIFO storage and the registered selection. There is no combinational path from `network_valid_i` to any output.

## Configuration
- `NOC_PORT_SINK_STATS_EN` defined: `stats_flits_o` increments by 1 per accepted (non-dropped) flit, wraps at 2^32, and resets to 0.
- Not defined: `stats_flits_o` is tied to 0 and the counter logic is absent.

## Test plan
- **Single-flit packet.** Reset, then send one `HeaderTailFlitType` flit on VC1 with payload 0xA5. Expect `m_valid_o`=1 at t+1 with `m_data_o` VC field = 1, payload 0xA5. After the transfer, `m_valid_o`=0.
- **Fill to full.** Send 4 flits to VC0 with `BufferDepth`=4 and `m_ready_i`=0. Expect `network_go_o[0]`=0 the cycle after the 4th write, `network_go_o[1]` still 1, and `overflow_o`=0.
- **Overflow.** From the previous state, drive a 5th flit on VC0. Expect the flit dropped, `overflow_o`=1 sticky, and the occupancy still 4.
- **Wormhole lock.** Interleave a 3-flit packet on VC0 (head, body, tail) with a single-flit packet on VC1, then set `m_ready_i`=1. Expect the three VC0 flits to leave contiguously; the VC1 flit must not appear before the VC0 tail.
- **Round-robin fairness.** Preload both VCs with two single-flit packets each and hold `m_ready_i`=1. Expect the output VC order 0,1,0,1.
- **Stats and full-FIFO bypass.** Keep VC0 full and read one flit while writing one in the same cycle. Expect the count to stay at 4 and no overflow. With `NOC_PORT_SINK_STATS_EN` defined, `stats_flits_o` increments by 1 for that write.

Source files
------------

// File: rtl/noc_port_sink_vc_buffer.sv
// Stop&Go link receiver: per-VC FIFOs with exact-credit go flags and a wormhole-aware
// round-robin drain arbiter. Define NOC_PORT_SINK_STATS_EN to enable the accepted-flit counter.
module noc_port_sink_vc_buffer #(
    parameter int NetworkFlitWidth               = 64,
    parameter int NetworkFlitTypeWidth           = 2,
    parameter int NetworkBroadcastWidth          = 1,
    parameter int NetworkVirtualChannelIdWidth   = 1,
    parameter int NetworkNumberOfVirtualChannels = 2,
    parameter int BufferDepth                    = 4,
    parameter logic [NetworkFlitTypeWidth-1:0] TailFlitType       = 2'b10,
    parameter logic [NetworkFlitTypeWidth-1:0] HeaderTailFlitType = 2'b11,
    localparam int NetworkDataWidth = NetworkFlitWidth + NetworkFlitTypeWidth
                                    + NetworkBroadcastWidth + NetworkVirtualChannelIdWidth
) (
    input  logic                                      clk_network_i,
    input  logic                                      rst_network_i,
    input  logic                                      network_valid_i,
    input  logic [NetworkDataWidth-1:0]               network_data_i,
    output logic [NetworkNumberOfVirtualChannels-1:0] network_go_o,
    output logic                                      m_valid_o,
    input  logic                                      m_ready_i,
    output logic [NetworkDataWidth-1:0]               m_data_o,
    output logic                                      overflow_o,
    output logic [31:0]                               stats_flits_o
);

    localparam int DW       = NetworkDataWidth;
    localparam int VCW      = NetworkVirtualChannelIdWidth;
    localparam int NVC      = NetworkNumberOfVirtualChannels;
    localparam int TW       = NetworkFlitTypeWidth;
    localparam int TYPE_LSB = VCW + NetworkBroadcastWidth;
    localparam int PW       = $clog2(BufferDepth);
    localparam int CW       = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BufferDepth);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    logic [DW-1:0]  mem_q    [NVC][BufferDepth];
    logic [PW-1:0]  wr_ptr_q [NVC];
    logic [PW-1:0]  wr_ptr_d [NVC];
    logic [PW-1:0]  rd_ptr_q [NVC];
    logic [PW-1:0]  rd_ptr_d [NVC];
    logic [CW-1:0]  count_q  [NVC];
    logic [CW-1:0]  count_d  [NVC];
    logic [NVC-1:0] go_q;
    logic [NVC-1:0] go_d;
    logic           overflow_q;
    logic           overflow_d;
    arb_state_e     state_q;
    arb_state_e     state_d;
    logic [VCW-1:0] rr_q;
    logic [VCW-1:0] rr_d;
    logic [VCW-1:0] sel_q;
    logic [VCW-1:0] sel_d;

    logic [VCW-1:0] wr_vc_s;
    logic           wr_blocked_s;
    logic           wr_accept_s;
    logic [NVC-1:0] wr_en_s;
    logic [NVC-1:0] rd_en_s;
    logic [DW-1:0]  head_s;
    logic [TW-1:0]  head_type_s;
    logic           head_last_s;
    logic           m_valid_s;
    logic           transfer_s;
    logic           pick_found_s;
    logic [VCW-1:0] pick_vc_s;

    function automatic logic [VCW-1:0] rr_index(input logic [VCW-1:0] base, input int offset);
        rr_index = VCW'((int'(base) + offset) % NVC);
    endfunction

    assign wr_vc_s     = network_data_i[VCW-1:0];
    assign head_s      = mem_q[sel_q][rd_ptr_q[sel_q]];
    assign head_type_s = head_s[TYPE_LSB +: TW];
    assign head_last_s = (head_type_s == TailFlitType) || (head_type_s == HeaderTailFlitType);
    assign m_valid_s   = (count_q[sel_q] != '0);
    assign transfer_s  = m_valid_s && m_ready_i;
    assign wr_accept_s = network_valid_i && !wr_blocked_s;

    // Read strobes: only the registered selection can be drained
    always_comb begin
        rd_en_s = '0;
        for (int v = 0; v < NVC; v++) begin
            rd_en_s[v] = transfer_s && (sel_q == VCW'(v));
        end
    end

    // A write is blocked when the VC id is out of range or the FIFO is full without a same-VC read
    always_comb begin
        wr_blocked_s = 1'b1;
        for (int v = 0; v < NVC; v++) begin
            if (wr_vc_s == VCW'(v)) begin
                wr_blocked_s = (count_q[v] == DEPTH_C) && !rd_en_s[v];
            end else begin
                wr_blocked_s = wr_blocked_s;
            end
        end
    end

    // Per-VC pointer, occupancy and credit next-state
    always_comb begin
        wr_en_s = '0;
        go_d    = '0;
        for (int v = 0; v < NVC; v++) begin
            wr_en_s[v]  = wr_accept_s && (wr_vc_s == VCW'(v));
            wr_ptr_d[v] = wr_en_s[v] ? (wr_ptr_q[v] + PW'(1)) : wr_ptr_q[v];
            rd_ptr_d[v] = rd_en_s[v] ? (rd_ptr_q[v] + PW'(1)) : rd_ptr_q[v];
            case ({wr_en_s[v], rd_en_s[v]})
                2'b10:   count_d[v] = count_q[v] + CW'(1);
                2'b01:   count_d[v] = count_q[v] - CW'(1);
                default: count_d[v] = count_q[v];
            endcase
            go_d[v] = (count_d[v] < DEPTH_C);
        end
    end

    assign overflow_d = overflow_q | (network_valid_i & wr_blocked_s);

    // Arbiter state and round-robin pointer next-state
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (transfer_s) begin
                    rr_d    = sel_q;
                    state_d = head_last_s ? IDLE : LOCKED;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (transfer_s && head_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin search over post-edge occupancy so a fresh flit is visible one cycle after its write
    always_comb begin
        pick_found_s = 1'b0;
        pick_vc_s    = sel_q;
        for (int i = 1; i <= NVC; i++) begin
            if (!pick_found_s && (count_d[rr_index(rr_d, i)] != '0)) begin
                pick_found_s = 1'b1;
                pick_vc_s    = rr_index(rr_d, i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Selection may only move while the output is idle or right after a transfer
    always_comb begin
        sel_d = sel_q;
        if ((!m_valid_s || transfer_s) && (state_d == IDLE) && pick_found_s) begin
            sel_d = pick_vc_s;
        end else begin
            sel_d = sel_q;
        end
    end

    // Control registers
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            wr_ptr_q   <= '{default: '0};
            rd_ptr_q   <= '{default: '0};
            count_q    <= '{default: '0};
            go_q       <= '1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            rr_q       <= VCW'(NVC - 1);
            sel_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            go_q       <= go_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
        end
    end

    // Flit storage; contents are don't-care until written
    always_ff @(posedge clk_network_i) begin
        for (int v = 0; v < NVC; v++) begin
            if (wr_en_s[v]) begin
                mem_q[v][wr_ptr_q[v]] <= network_data_i;
            end
        end
    end

`ifdef NOC_PORT_SINK_STATS_EN
    logic [31:0] stats_q;
    logic [31:0] stats_d;

    assign stats_d = stats_q + {31'd0, wr_accept_s};

    // Accepted-flit counter, wraps naturally
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            stats_q <= 32'd0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign stats_flits_o = stats_q;
`else
    assign stats_flits_o = 32'd0;
`endif

    assign network_go_o = go_q;
    assign overflow_o   = overflow_q;
    assign m_valid_o    = m_valid_s;
    assign m_data_o     = m_valid_s ? head_s : '0;

endmodule

// File: tb/tb_noc_port_sink_vc_buffer.sv
// Scoreboard bench for noc_port_sink_vc_buffer: directed stimulus pushes expected output flits,
// an independent monitor pops and compares on every output handshake.
module tb_noc_port_sink_vc_buffer;

    localparam int DW = 68;
    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          net_valid;
    logic [DW-1:0] net_data;
    logic [1:0]    net_go;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          overflow;
    logic [31:0]   stats;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    noc_port_sink_vc_buffer dut (
        .clk_network_i   (clk),
        .rst_network_i   (rst),
        .network_valid_i (net_valid),
        .network_data_i  (net_data),
        .network_go_o    (net_go),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .m_data_o        (m_data),
        .overflow_o      (overflow),
        .stats_flits_o   (stats)
    );

    function automatic logic [DW-1:0] mk(input logic [63:0] p, input logic [1:0] t, input logic v);
        return {p, t, 1'b0, v};
    endfunction

    function automatic logic [31:0] stat_exp(input int n);
`ifdef NOC_PORT_SINK_STATS_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n * 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] p, input logic [1:0] t, input logic v);
        net_valid = 1'b1;
        net_data  = mk(p, t, v);
        @(posedge clk);
        #1;
        net_valid = 1'b0;
        net_data  = '0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        m_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every output handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got %h want none", m_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL out_data got %h want %h", m_data, e);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        net_valid = 1'b0;
        net_data  = '0;
        m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_go", net_go, 2'b11);
        chk("reset_valid", m_valid, 1'b0);
        chk("reset_data", m_data, '0);
        chk("reset_ovf", overflow, 1'b0);
        chk("reset_stats", stats, 32'd0);

        // single-flit packet on VC1
        send(64'hA5, T_HT, 1'b1);
        chk("single_valid", m_valid, 1'b1);
        chk("single_data", m_data, mk(64'hA5, T_HT, 1'b1));
        exp_q.push_back(mk(64'hA5, T_HT, 1'b1));
        drain();
        chk("single_empty", m_valid, 1'b0);

        // fill VC0
        for (int i = 0; i < 4; i++) begin
            send(64'h10 + 64'(i), T_HT, 1'b0);
            if (i == 2) chk("fill3_go", net_go, 2'b11);
        end
        chk("fill_go", net_go, 2'b10);
        chk("fill_ovf", overflow, 1'b0);
        chk("fill_stats", stats, stat_exp(5));

        // full-FIFO bypass: read and write VC0 in the same cycle
        exp_q.push_back(mk(64'h10, T_HT, 1'b0));
        m_ready   = 1'b1;
        net_valid = 1'b1;
        net_data  = mk(64'h15, T_HT, 1'b0);
        @(posedge clk);
        #1;
        m_ready   = 1'b0;
        net_valid = 1'b0;
        net_data  = '0;
        chk("bypass_go", net_go, 2'b10);
        chk("bypass_ovf", overflow, 1'b0);
        chk("bypass_stats", stats, stat_exp(6));
        chk("bypass_head", m_data, mk(64'h11, T_HT, 1'b0));

        // overflow: 5th flit dropped
        send(64'h16, T_HT, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_go", net_go, 2'b10);
        chk("ovf_stats", stats, stat_exp(6));
        exp_q.push_back(mk(64'h11, T_HT, 1'b0));
        exp_q.push_back(mk(64'h12, T_HT, 1'b0));
        exp_q.push_back(mk(64'h13, T_HT, 1'b0));
        exp_q.push_back(mk(64'h15, T_HT, 1'b0));
        drain();
        chk("ovf_sticky", overflow, 1'b1);
        chk("drained_go", net_go, 2'b11);
        chk("drained_valid", m_valid, 1'b0);

        // wormhole lock: VC1 single must not split the VC0 packet
        send(64'h20, T_HEAD, 1'b0);
        send(64'h30, T_HT,   1'b1);
        send(64'h21, T_BODY, 1'b0);
        send(64'h22, T_TAIL, 1'b0);
        exp_q.push_back(mk(64'h20, T_HEAD, 1'b0));
        exp_q.push_back(mk(64'h21, T_BODY, 1'b0));
        exp_q.push_back(mk(64'h22, T_TAIL, 1'b0));
        exp_q.push_back(mk(64'h30, T_HT,   1'b1));
        drain();

        // round-robin fairness
        send(64'h40, T_HT, 1'b0);
        send(64'h50, T_HT, 1'b1);
        send(64'h41, T_HT, 1'b0);
        send(64'h51, T_HT, 1'b1);
        exp_q.push_back(mk(64'h40, T_HT, 1'b0));
        exp_q.push_back(mk(64'h50, T_HT, 1'b1));
        exp_q.push_back(mk(64'h41, T_HT, 1'b0));
        exp_q.push_back(mk(64'h51, T_HT, 1'b1));
        drain();

        // reset mid-packet while locked on VC0
        send(64'h60, T_HEAD, 1'b0);
        send(64'h61, T_BODY, 1'b0);
        exp_q.push_back(mk(64'h60, T_HEAD, 1'b0));
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("locked_head", m_data, mk(64'h61, T_BODY, 1'b0));
        rst = 1'b1;
        #1;
        chk("midrst_valid", m_valid, 1'b0);
        chk("midrst_go", net_go, 2'b11);
        chk("midrst_ovf", overflow, 1'b0);
        chk("midrst_stats", stats, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(64'h70, T_HT, 1'b1);
        exp_q.push_back(mk(64'h70, T_HT, 1'b1));
        drain();
        chk("final_valid", m_valid, 1'b0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
